// File: rtl/uart_tx_frame_sched_if.sv
// Requester/TX-core bundle for uart_tx_frame_sched.
// The scheduler uses the master view; the game logic and TX core side use slave.
interface uart_tx_frame_sched_if #(
   parameter int unsigned N_REQ = 2
);
   logic [N_REQ-1:0]    req_valid;
   logic [32*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]    req_ready;
   logic                tx_start;
   logic [7:0]          tx_data;
   logic                tx_done;
   logic                busy;
   logic                timeout_err;

   modport master (
      input  req_valid, req_data, tx_done,
      output req_ready, tx_start, tx_data, busy, timeout_err
   );

   modport slave (
      output req_valid, req_data, tx_done,
      input  req_ready, tx_start, tx_data, busy, timeout_err
   );
endinterface

// File: rtl/uart_tx_frame_sched.sv
// Round-robin scheduler that sends a granted 32-bit game word as a 5-byte UART frame:
// header (HDR_BASE | index) followed by the word bytes LSB first, one byte per TX handshake.
module uart_tx_frame_sched #(
   parameter int unsigned N_REQ          = 2,
   parameter logic [7:0]  HDR_BASE       = 8'hA0,
   parameter int unsigned GAP_CYCLES     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input logic                   clk,
   input logic                   rst,
   uart_tx_frame_sched_if.master bus
);
   localparam int unsigned CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam int unsigned IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, GAP} state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [31:0]      word_q, word_d;
   logic [2:0]       bidx_q, bidx_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N_REQ-1:0] ready_q, ready_d;
   logic             start_q, start_d;
   logic [7:0]       data_q, data_d;
   logic             busy_q, busy_d;
   logic             terr_q, terr_d;

   logic             found;
   logic [IW-1:0]    pick;
   logic [IW:0]      rr_j;
   logic [31:0]      req_word;
   logic [7:0]       word_byte;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         word_q  <= '0;
         bidx_q  <= '0;
         cnt_q   <= '0;
         ready_q <= '0;
         start_q <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         bidx_q  <= bidx_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         start_q <= start_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         terr_q  <= terr_d;
      end
   end

   always_comb begin
      found     = 1'b0;
      pick      = '0;
      rr_j      = '0;
      req_word  = '0;
      word_byte = '0;
      state_d   = state_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      word_d    = word_q;
      bidx_d    = bidx_q;
      cnt_d     = cnt_q;
      ready_d   = '0;
      start_d   = 1'b0;
      data_d    = data_q;
      terr_d    = 1'b0;

      // First requester at or after the pointer, wrapping modulo N_REQ.
      for (int unsigned i = 0; i < N_REQ; i++) begin
         rr_j = {1'b0, ptr_q} + (IW+1)'(i);
         if (rr_j >= (IW+1)'(N_REQ)) rr_j = rr_j - (IW+1)'(N_REQ);
         if (!found && bus.req_valid[rr_j[IW-1:0]]) begin
            found = 1'b1;
            pick  = rr_j[IW-1:0];
         end
      end
      for (int unsigned i = 0; i < N_REQ; i++)
         if (pick == IW'(i)) req_word = bus.req_data[32*i +: 32];
      for (int unsigned b = 0; b < 4; b++)
         if (bidx_q == 3'(b)) word_byte = word_q[8*b +: 8];

      unique case (state_q)
         IDLE: if (found) begin
            idx_d         = pick;
            word_d        = req_word;
            ready_d[pick] = 1'b1;
            ptr_d         = (pick == IW'(N_REQ - 1)) ? '0 : pick + 1'b1;
            state_d       = LOAD;
         end
         // LOAD and SEND both issue the start pulse on exit, so tx_start is high
         // during the first WAIT cycle; that keeps header and data latencies exact.
         LOAD: begin
            data_d  = HDR_BASE | 8'(idx_q);
            bidx_d  = '0;
            start_d = 1'b1;
            cnt_d   = '0;
            state_d = WAIT;
         end
         SEND: begin
            start_d = 1'b1;
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (bus.tx_done && !start_q) begin
               cnt_d = '0;
               if (bidx_q == 3'd4) begin
                  state_d = GAP;
               end else begin
                  data_d  = word_byte;
                  bidx_d  = bidx_q + 1'b1;
                  state_d = SEND;
               end
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               terr_d  = 1'b1;
               cnt_d   = '0;
               state_d = GAP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         GAP: begin
            if (cnt_q == CW'(GAP_CYCLES - 1)) state_d = IDLE;
            else cnt_d = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   assign bus.req_ready   = ready_q;
   assign bus.tx_start    = start_q;
   assign bus.tx_data     = data_q;
   assign bus.busy        = busy_q;
   assign bus.timeout_err = terr_q;
endmodule
